// File: rtl/spi_cmd_sched.sv
// SPI frame command scheduler: queues frames, decodes them and drives cfg writes or engine runs.
// Latency: a queued frame is popped 1 cycle after it is pushed; non-RUN commands retire 3 cycles after the pop.
// Backpressure: none upstream; a frame arriving with the queue full is dropped and flagged on o_ovf.
module spi_cmd_sched #(
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_sys,
    input  logic             rstb,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_opcode,
    input  logic [4:0][15:0] i_in_data,
    output logic             o_eng_start,
    output logic [3:0]       o_eng_op,
    output logic [63:0]      o_eng_operand,
    input  logic             i_eng_done,
    output logic             o_eng_abort,
    output logic [3:0][15:0] o_cfg_reg,
    output logic             o_busy,
    output logic             o_ovf,
    output logic             o_tmo,
    output logic [7:0]       o_err_count,
    output logic [15:0]      o_run_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QFULL   = CW'(QDEPTH);
    localparam logic [15:0]   TM_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WAIT_DONE} state_t;
    typedef enum logic [2:0] {C_NOP, C_WRITE, C_RUN, C_CLEAR, C_ILL} cmd_t;

    logic             r_rst_n;
    logic [87:0]      r_mem [QDEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    cmd_t             r_cmd;
    logic [7:0]       r_hold_op;
    logic [4:0][15:0] r_hold_dat;
    logic [15:0]      r_timer;

    logic [87:0]      w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_unused_word0;

    assign w_head = r_mem[r_rptr];
    assign w_push = i_in_valid && (r_count != QFULL);
    assign w_drop = i_in_valid && (r_count == QFULL);
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign o_busy = (r_state != S_IDLE) || (r_count != '0);
    // Upper word0 bits carry no meaning for any opcode.
    assign w_unused_word0 = ^r_hold_dat[0][15:4];

    // Reset assertion is immediate; release is retimed by one flop so the first push lands on the second edge.
    always_ff @(posedge clk_sys or negedge rstb) begin
        if (!rstb) r_rst_n <= 1'b0;
        else       r_rst_n <= 1'b1;
    end

    // Frame storage; contents are only meaningful below r_count, so no reset is needed.
    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wptr] <= {i_in_opcode, i_in_data};
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_sys or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Command FSM with all registered outputs, counters and sticky flags.
    always_ff @(posedge clk_sys or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state       <= S_IDLE;
            r_cmd         <= C_NOP;
            r_hold_op     <= '0;
            r_hold_dat    <= '0;
            r_timer       <= '0;
            o_eng_start   <= 1'b0;
            o_eng_abort   <= 1'b0;
            o_eng_op      <= '0;
            o_eng_operand <= '0;
            o_cfg_reg     <= '0;
            o_ovf         <= 1'b0;
            o_tmo         <= 1'b0;
            o_err_count   <= '0;
            o_run_count   <= '0;
        end else begin
            o_eng_start <= 1'b0;
            o_eng_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold_op  <= w_head[87:80];
                        r_hold_dat <= w_head[79:0];
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (r_hold_op)
                        8'h00:   r_cmd <= C_NOP;
                        8'h01:   r_cmd <= C_WRITE;
                        8'h02:   r_cmd <= C_RUN;
                        8'h03:   r_cmd <= C_CLEAR;
                        default: r_cmd <= C_ILL;
                    endcase
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    case (r_cmd)
                        C_WRITE: o_cfg_reg[r_hold_dat[0][1:0]] <= r_hold_dat[1];
                        C_RUN: begin
                            o_eng_op      <= r_hold_dat[0][3:0];
                            o_eng_operand <= r_hold_dat[4:1];
                            o_eng_start   <= 1'b1;
                            r_timer       <= '0;
                            r_state       <= S_WAIT_DONE;
                        end
                        C_CLEAR: begin
                            o_ovf       <= 1'b0;
                            o_tmo       <= 1'b0;
                            o_err_count <= '0;
                        end
                        C_ILL: begin
                            if (o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_WAIT_DONE: begin
                    // A completion on the final timer cycle wins over the timeout.
                    if (i_eng_done) begin
                        o_run_count <= o_run_count + 1'b1;
                        r_state     <= S_IDLE;
                    end else if (r_timer == TM_LAST) begin
                        o_tmo       <= 1'b1;
                        o_eng_abort <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Placed last so a drop beats a same-cycle CLEAR.
            if (w_drop) o_ovf <= 1'b1;
        end
    end

endmodule

// File: doc/spi_cmd_sched.md
SPI_CMD_SCHED -- requirements
Module: spi_cmd_sched

Parameters
REQ-001 QDEPTH, default 4: frame queue depth in entries; power of two, 2 to 16.
REQ-002 TIMEOUT, default 1024: maximum number of WAIT_DONE cycles before a run is aborted; range 2 to 65535.

Interface
REQ-003 clk_sys  in  1  system clock; all logic is rising-edge.
REQ-004 rstb  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  one-cycle pulse; a complete SPI frame is present on in_opcode/in_data.
REQ-006 in_opcode  in  8  frame opcode.
REQ-007 in_data  in  16 x [4:0]  frame payload words; word 0 is the first word of the frame.
REQ-008 eng_start  out  1  one-cycle pulse that launches the engine.
REQ-009 eng_op  out  4  engine operation; held stable from eng_start until the run ends.
REQ-010 eng_operand  out  64  packed {in_data[4], in_data[3], in_data[2], in_data[1]}; held like eng_op.
REQ-011 eng_done  in  1  engine completion pulse.
REQ-012 eng_abort  out  1  one-cycle pulse that kills the engine after a timeout.
REQ-013 cfg_reg  out  16 x [3:0]  configuration registers.
REQ-014 busy  out  1  high when the FSM is not in IDLE or the queue is non-empty.
REQ-015 ovf  out  1  sticky: a frame was dropped.
REQ-016 tmo  out  1  sticky: an engine run timed out.
REQ-017 err_count  out  8  count of illegal opcodes; saturates at 255.
REQ-018 run_count  out  16  count of completed runs; wraps at 2^16.

Function
REQ-019 The queue SHALL be a FIFO of QDEPTH entries, each entry being {opcode, 5 payload words} (88 bits).
REQ-020 in_valid with occupancy < QDEPTH SHALL push the frame at that edge.
REQ-021 in_valid with occupancy == QDEPTH SHALL drop the frame and set ovf, even if a pop occurs in the same cycle.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged; read and write pointers SHALL wrap modulo QDEPTH.
REQ-023 The FSM SHALL have exactly four states: IDLE, DECODE, EXEC, WAIT_DONE.
REQ-024 IDLE with the queue non-empty: pop the head entry into a hold register, then go to DECODE on the next edge.
REQ-025 DECODE SHALL take one cycle, latch the decoded command and go to EXEC.
REQ-026 Opcode 0x00 (NOP) in EXEC: no effect; return to IDLE.
REQ-027 Opcode 0x01 (WRITE) in EXEC: cfg_reg[word0[1:0]] <= word1; return to IDLE. Word0[15:2] SHALL be ignored.
REQ-028 Opcode 0x02 (RUN) in EXEC: drive eng_op = word0[3:0], drive eng_operand, pulse eng_start for one cycle, clear the timer and go to WAIT_DONE.
REQ-029 Opcode 0x03 (CLEAR) in EXEC: clear ovf, tmo and err_count; return to IDLE. If a drop occurs in the same cycle, ovf SHALL be set (set wins).
REQ-030 Any other opcode in EXEC: err_count increments, saturating at 255; return to IDLE.
REQ-031 WAIT_DONE: the timer SHALL increment every cycle.
REQ-032 eng_done in WAIT_DONE SHALL increment run_count and return the FSM to IDLE.
REQ-033 When the timer reaches TIMEOUT-1 without eng_done: set tmo, pulse eng_abort for one cycle, return to IDLE.
REQ-034 eng_done and timer == TIMEOUT-1 in the same cycle SHALL count as a completion; tmo SHALL NOT be set and eng_abort SHALL NOT pulse.
REQ-035 eng_done outside WAIT_DONE SHALL be ignored.
REQ-036 Frames SHALL keep being accepted into the queue in every state.
REQ-037 Minimum turnaround SHALL be 3 cycles per non-RUN command (IDLE, DECODE, EXEC).

Reset
REQ-038 rstb low SHALL asynchronously set: FSM = IDLE; queue empty with both pointers 0.
REQ-039 rstb low SHALL also clear cfg_reg, eng_op, eng_operand, err_count, run_count, ovf, tmo and the timer to 0.
REQ-040 During reset eng_start, eng_abort and busy SHALL be 0.
REQ-041 Reset during WAIT_DONE SHALL abandon the run without pulsing eng_abort.
REQ-042 Release of rstb SHALL be synchronised to clk_sys inside the block; the first push is accepted on the second edge after release.

Verification
REQ-043 WRITE frame opcode 0x01, word0 = 0x0002, word1 = 0xBEEF -> cfg_reg[2] = 0xBEEF 3 cycles after the pop; other cfg_reg stay 0; busy falls afterwards.
REQ-044 RUN frame, word0 = 0x0005, eng_done 10 cycles after eng_start -> single eng_start pulse, eng_op = 5, run_count = 1, tmo = 0.
REQ-045 RUN frame with no eng_done, TIMEOUT = 16 -> eng_abort exactly 16 cycles after eng_start, tmo = 1; a following CLEAR frame sets tmo = 0.
REQ-046 Six back-to-back in_valid pulses while the FSM is in WAIT_DONE, QDEPTH = 4 -> 4 frames queued, ovf = 1; the 4 queued frames execute in push order after eng_done.
REQ-047 300 frames with opcode 0x7F -> err_count = 255 (saturated); no cfg_reg changes.
REQ-048 rstb asserted mid-WAIT_DONE with 2 frames queued -> all outputs 0 immediately; no command executes after release until a new frame arrives.
